// File: rtl/y_writeback_ctrl_pkg.sv
// Shared definitions for the Y write-back controller: row geometry, FSM encoding,
// the queued request layout and the lane-merge helper.
package y_writeback_ctrl_pkg;

    localparam int LANE_W    = 64;
    localparam int VAL_W     = 48;
    localparam int ROW_W     = 256;
    localparam int ADDR_W    = 11;
    localparam int NUM_LANES = 4;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_RD    = 3'd2;
    localparam logic [2:0] ST_MERGE = 3'd3;
    localparam logic [2:0] ST_WR    = 3'd4;

    typedef struct packed {
        logic [VAL_W-1:0]     y_val;
        logic [ADDR_W-1:0]    diag_addr;
        logic [NUM_LANES-1:0] diag_one_hot;
        logic [ADDR_W-1:0]    non_diag_addr;
        logic [NUM_LANES-1:0] non_diag_one_hot;
        logic                 last;
    } wb_req_t;

    // Only the low VAL_W bits of a selected lane are replaced; the lane's top bits
    // and every unselected lane pass through untouched.
    function automatic logic [ROW_W-1:0] merge_lanes(
        input logic [ROW_W-1:0]     row,
        input logic [VAL_W-1:0]     val,
        input logic [NUM_LANES-1:0] sel
    );
        logic [ROW_W-1:0] merged;
        merged = row;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (sel[k]) begin
                merged[k*LANE_W +: VAL_W] = val;
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/y_wb_fifo.sv
// Synchronous request FIFO with occupancy count; DEPTH must be a power of two so the
// pointers wrap naturally.
module y_wb_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [W-1:0]  store [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = store[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/y_writeback_ctrl.sv
// Y write-back controller: queues Y updates and performs a lane-merging
// read-modify-write into the Y SRAM for the diagonal and off-diagonal rows.
module y_writeback_ctrl #(
    parameter int DEPTH  = 4,
    parameter int LANE_W = 64,
    parameter int VAL_W  = 48
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wb_valid,
    output logic                  wb_ready,
    input  logic [VAL_W-1:0]      wb_yVal,
    input  logic [10:0]           wb_diagAddr,
    input  logic [3:0]            wb_diagOneHot,
    input  logic [10:0]           wb_nonDiagAddr,
    input  logic [3:0]            wb_nonDiagOneHot,
    input  logic                  wb_last,
    output logic [10:0]           mem_addr,
    output logic                  mem_rdEn,
    input  logic [4*LANE_W-1:0]   mem_rdData,
    output logic                  mem_wrEn,
    output logic [4*LANE_W-1:0]   mem_wrData,
    output logic                  wb_busy,
    output logic                  wb_done
);
    import y_writeback_ctrl_pkg::*;

    wb_req_t                in_req;
    wb_req_t                head_req;
    wb_req_t                cur_req;
    logic                   push;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;

    logic [2:0]             state;
    logic                   pend_diag;
    logic                   pend_nd;
    logic                   load_done;
    logic [ADDR_W-1:0]      op_addr;
    logic [NUM_LANES-1:0]   op_sel;
    logic [ROW_W-1:0]       merged;

    assign in_req = {wb_yVal, wb_diagAddr, wb_diagOneHot, wb_nonDiagAddr, wb_nonDiagOneHot, wb_last};

    y_wb_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(wb_req_t))
    ) u_fifo (
        .clk   (clock),
        .rst_n (reset),
        .push  (push),
        .pop   (pop),
        .wdata (in_req),
        .rdata (head_req),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Handshake: a request transfers on any cycle where wb_valid and wb_ready are both
    // high. wb_ready depends only on the FIFO count, never on a pop in the same cycle.
    assign wb_ready  = !fifo_full;
    assign push      = wb_valid && wb_ready;
    assign load_done = (state == ST_LOAD) && !pend_diag && !pend_nd;
    assign pop       = !fifo_empty && ((state == ST_IDLE) || load_done);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            cur_req   <= '0;
            pend_diag <= 1'b0;
            pend_nd   <= 1'b0;
            op_addr   <= '0;
            op_sel    <= '0;
            merged    <= '0;
            wb_done   <= 1'b0;
        end else begin
            wb_done <= 1'b0;
            if (pop) begin
                cur_req   <= head_req;
                pend_diag <= |head_req.diag_one_hot;
                pend_nd   <= |head_req.non_diag_one_hot;
                state     <= ST_LOAD;
            end
            case (state)
                ST_IDLE: ;
                ST_LOAD: begin
                    if (pend_diag) begin
                        op_addr   <= cur_req.diag_addr;
                        op_sel    <= cur_req.diag_one_hot;
                        pend_diag <= 1'b0;
                        state     <= ST_RD;
                    end else if (pend_nd) begin
                        op_addr   <= cur_req.non_diag_addr;
                        op_sel    <= cur_req.non_diag_one_hot;
                        pend_nd   <= 1'b0;
                        state     <= ST_RD;
                    end else begin
                        // A request with real sub-ops already flagged done at its last WR.
                        if (cur_req.diag_one_hot == '0 && cur_req.non_diag_one_hot == '0) begin
                            wb_done <= cur_req.last;
                        end
                        if (!pop) state <= ST_IDLE;
                    end
                end
                ST_RD: state <= ST_MERGE;
                ST_MERGE: begin
                    merged <= merge_lanes(mem_rdData, cur_req.y_val, op_sel);
                    state  <= ST_WR;
                end
                ST_WR: begin
                    if (!pend_diag && !pend_nd) wb_done <= cur_req.last;
                    state <= ST_LOAD;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign mem_rdEn   = (state == ST_RD);
    assign mem_wrEn   = (state == ST_WR);
    assign mem_addr   = (mem_rdEn || mem_wrEn) ? op_addr : '0;
    assign mem_wrData = mem_wrEn ? merged : '0;
    assign wb_busy    = (fifo_count != '0) || (state != ST_IDLE);

endmodule

// File: tb/tb_y_writeback_ctrl.sv
// Bench for y_writeback_ctrl: directed scenarios plus randomized traffic scored
// against a request-level model of the Y SRAM contents.
module tb_y_writeback_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         wb_valid = 1'b0;
    logic         wb_ready;
    logic [47:0]  wb_yVal = '0;
    logic [10:0]  wb_diagAddr = '0;
    logic [3:0]   wb_diagOneHot = '0;
    logic [10:0]  wb_nonDiagAddr = '0;
    logic [3:0]   wb_nonDiagOneHot = '0;
    logic         wb_last = 1'b0;
    logic [10:0]  mem_addr;
    logic         mem_rdEn;
    logic [255:0] mem_rdData;
    logic         mem_wrEn;
    logic [255:0] mem_wrData;
    logic         wb_busy;
    logic         wb_done;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_done = 0;
    int obs_done = 0;

    logic [255:0] sram    [0:2047];
    logic [255:0] ref_mem [0:2047];
    logic [255:0] rd_q = '0;
    logic [10:0]  exp_addr_q [$];
    logic [255:0] exp_q      [$];

    always #5 clk = ~clk;

    y_writeback_ctrl #(.DEPTH(4), .LANE_W(64), .VAL_W(48)) dut (
        .clock            (clk),
        .reset            (rst_n),
        .wb_valid         (wb_valid),
        .wb_ready         (wb_ready),
        .wb_yVal          (wb_yVal),
        .wb_diagAddr      (wb_diagAddr),
        .wb_diagOneHot    (wb_diagOneHot),
        .wb_nonDiagAddr   (wb_nonDiagAddr),
        .wb_nonDiagOneHot (wb_nonDiagOneHot),
        .wb_last          (wb_last),
        .mem_addr         (mem_addr),
        .mem_rdEn         (mem_rdEn),
        .mem_rdData       (mem_rdData),
        .mem_wrEn         (mem_wrEn),
        .mem_wrData       (mem_wrData),
        .wb_busy          (wb_busy),
        .wb_done          (wb_done)
    );

    // SRAM: one-cycle read latency, a write is visible to a read on the next cycle
    always @(posedge clk) begin
        if (mem_wrEn) sram[mem_addr] <= mem_wrData;
        if (mem_rdEn) rd_q <= sram[mem_addr];
    end
    assign mem_rdData = rd_q;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Lane k of a row is bits [64k+63:64k]; a written lane keeps its top 16 bits.
    function automatic logic [255:0] ref_write(input logic [255:0] row, input logic [47:0] v,
                                               input logic [3:0] lanes);
        logic [255:0] r;
        logic [63:0]  lane_word;
        r = row;
        for (int k = 0; k < 4; k++) begin
            lane_word = row[k*64 +: 64];
            if (lanes[k]) r[k*64 +: 64] = {lane_word[63:48], v};
        end
        return r;
    endfunction

    function automatic logic [255:0] rand_row();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic model_push(input logic [47:0] v, input logic [10:0] da, input logic [3:0] dm,
                              input logic [10:0] na, input logic [3:0] nm, input bit lst);
        if (dm != 4'd0) begin
            ref_mem[da] = ref_write(ref_mem[da], v, dm);
            exp_addr_q.push_back(da);
            exp_q.push_back(ref_mem[da]);
        end
        if (nm != 4'd0) begin
            ref_mem[na] = ref_write(ref_mem[na], v, nm);
            exp_addr_q.push_back(na);
            exp_q.push_back(ref_mem[na]);
        end
        if (lst) exp_done++;
    endtask

    // Returns just after the accepting edge with wb_valid still high; follow with
    // another push_req or end_push.
    task automatic push_req(input logic [47:0] v, input logic [10:0] da, input logic [3:0] dm,
                            input logic [10:0] na, input logic [3:0] nm, input bit lst,
                            input bit use_model);
        int waited;
        waited = 0;
        @(negedge clk);
        wb_valid = 1'b1;
        wb_yVal = v;
        wb_diagAddr = da;
        wb_diagOneHot = dm;
        wb_nonDiagAddr = na;
        wb_nonDiagOneHot = nm;
        wb_last = lst;
        while (!wb_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!wb_ready) begin
            check("push_ready_timeout", wb_ready, 1);
            wb_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (use_model) model_push(v, da, dm, na, nm, lst);
    endtask

    task automatic end_push();
        @(negedge clk);
        wb_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int waited;
        waited = 0;
        while (wb_busy && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        check("idle_timeout", wb_busy, 0);
        repeat (3) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_wrEn) begin
                check("rd_wr_exclusive", mem_rdEn, 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_write", mem_wrEn, 0);
                end else begin
                    check("wr_addr", mem_addr, exp_addr_q.pop_front());
                    check("wr_data", mem_wrData, exp_q.pop_front());
                end
            end
            if (wb_done) obs_done++;
        end
    end

    initial begin
        int rd_at, wr_at, done_at, done_cnt, acc_cnt, seen;
        logic [47:0] v;
        logic [10:0] da, na;
        logic [3:0]  dm, nm;
        bit          lst;

        for (int i = 0; i < 2048; i++) begin
            sram[i] = '0;
            ref_mem[i] = '0;
        end
        sram[11'h005] = {4{64'hAAAA_0000_0000_0000}};
        ref_mem[11'h005] = sram[11'h005];
        for (int i = 0; i < 8; i++) begin
            sram[11'h200 + 11'(i)] = rand_row();
            ref_mem[11'h200 + 11'(i)] = sram[11'h200 + 11'(i)];
        end
        sram[11'h010] = rand_row();
        ref_mem[11'h010] = sram[11'h010];
        sram[11'h020] = rand_row();
        ref_mem[11'h020] = sram[11'h020];

        // reset state
        repeat (3) @(negedge clk);
        check("rst_ready", wb_ready, 1);
        check("rst_busy", wb_busy, 0);
        check("rst_done", wb_done, 0);
        check("rst_rden", mem_rdEn, 0);
        check("rst_wren", mem_wrEn, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wrdata", mem_wrData, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single diag request with cycle-exact latency
        push_req(48'h123456_654321, 11'h005, 4'b0100, 11'h000, 4'b0000, 1'b1, 1'b1);
        rd_at = 0; wr_at = 0; done_at = 0; done_cnt = 0; acc_cnt = 0;
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            if (n == 1) wb_valid = 1'b0;
            if (mem_rdEn) begin acc_cnt++; if (rd_at == 0) rd_at = n; end
            if (mem_wrEn) begin acc_cnt++; if (wr_at == 0) wr_at = n; end
            if (wb_done) begin done_cnt++; if (done_at == 0) done_at = n; end
        end
        check("t1_rd_cycle", rd_at, 3);
        check("t1_wr_cycle", wr_at, 5);
        check("t1_done_cycle", done_at, 6);
        check("t1_done_once", done_cnt, 1);
        check("t1_access_count", acc_cnt, 2);
        check("t1_row", sram[11'h005], {64'hAAAA_0000_0000_0000, 64'hAAAA_1234_5665_4321,
                                        64'hAAAA_0000_0000_0000, 64'hAAAA_0000_0000_0000});
        wait_idle();

        // symmetric pair: write order checked by the scoreboard
        v = 48'($urandom()) ^ (48'($urandom()) << 16);
        push_req(v, 11'h010, 4'b0010, 11'h020, 4'b1000, 1'b0, 1'b1);
        end_push();
        wait_idle();
        check("t2_row_diag", sram[11'h010], ref_mem[11'h010]);
        check("t2_row_nondiag", sram[11'h020], ref_mem[11'h020]);
        check("t2_writes_drained", exp_q.size(), 0);

        // same address for both sub-ops: second merge must see the first write
        v = 48'hBEEF_0123_4567;
        push_req(v, 11'h030, 4'b0001, 11'h030, 4'b1000, 1'b1, 1'b1);
        end_push();
        wait_idle();
        check("t3_same_addr_row", sram[11'h030], {16'h0, v, 64'h0, 64'h0, 16'h0, v});

        // back-pressure: six back-to-back requests, only the last one tagged
        for (int i = 0; i < 6; i++) begin
            v = 48'($urandom()) ^ (48'($urandom()) << 16);
            push_req(v, 11'h100 + 11'(i), 4'(1 << (i % 4)), 11'h000, 4'b0000, i == 5, 1'b1);
            if (i == 4) begin
                @(negedge clk);
                check("bp_ready_low", wb_ready, 0);
            end
        end
        end_push();
        wait_idle();
        for (int i = 0; i < 6; i++) check("bp_row", sram[11'h100 + 11'(i)], ref_mem[11'h100 + 11'(i)]);
        check("bp_done_count", obs_done, exp_done);

        // skip request: no SRAM traffic, done still pulses
        push_req(48'h0, 11'h000, 4'b0000, 11'h000, 4'b0000, 1'b1, 1'b1);
        acc_cnt = 0; done_cnt = 0;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (n == 1) wb_valid = 1'b0;
            if (mem_rdEn || mem_wrEn) acc_cnt++;
            if (wb_done) done_cnt++;
        end
        check("skip_no_access", acc_cnt, 0);
        check("skip_done", done_cnt, 1);

        // randomized traffic over a small address pool
        for (int r = 0; r < 40; r++) begin
            v  = 48'($urandom()) ^ (48'($urandom()) << 16);
            da = 11'h200 + 11'($urandom_range(0, 7));
            na = 11'h200 + 11'($urandom_range(0, 7));
            dm = 4'($urandom_range(0, 15));
            nm = 4'($urandom_range(0, 15));
            lst = ($urandom_range(0, 3) == 0);
            push_req(v, da, dm, na, nm, lst, 1'b1);
            if ($urandom_range(0, 2) == 0) begin
                end_push();
                repeat ($urandom_range(0, 6)) @(negedge clk);
            end
        end
        end_push();
        wait_idle();
        for (int i = 0; i < 8; i++) check("rand_row", sram[11'h200 + 11'(i)], ref_mem[11'h200 + 11'(i)]);
        check("rand_writes_drained", exp_q.size(), 0);
        check("rand_done_count", obs_done, exp_done);

        // reset during MERGE: request is dropped with no write
        push_req(48'hFFFF_FFFF_FFFF, 11'h040, 4'b0001, 11'h000, 4'b0000, 1'b1, 1'b0);
        end_push();
        seen = 0;
        for (int n = 0; n < 20 && seen == 0; n++) begin
            if (mem_rdEn) seen = 1;
            else @(negedge clk);
        end
        check("rst_saw_read", seen, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mrst_wren", mem_wrEn, 0);
        check("mrst_rden", mem_rdEn, 0);
        check("mrst_addr", mem_addr, 0);
        check("mrst_wrdata", mem_wrData, 0);
        check("mrst_busy", wb_busy, 0);
        check("mrst_done", wb_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        check("mrst_ready", wb_ready, 1);
        acc_cnt = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (mem_wrEn || mem_rdEn || wb_done) acc_cnt++;
        end
        check("mrst_no_activity", acc_cnt, 0);
        check("mrst_row_kept", sram[11'h040], ref_mem[11'h040]);
        check("final_done_count", obs_done, exp_done);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
